// File: rtl/qpsk_pkg.sv
// Shared QPSK symbol/sample field definitions for the packer and unzip blocks.
package qpsk_pkg;

  localparam int SYM_BITS       = 8;
  localparam int COMP_BITS      = 4;
  localparam int SAMP_COMP_BITS = 16;
  localparam int SYMS_PER_WORD  = 4;
  localparam int WORD_BITS      = SYM_BITS * SYMS_PER_WORD;
  localparam int SAMP_BITS      = 2 * SAMP_COMP_BITS;

  localparam int I_HI = 7;
  localparam int I_LO = 4;
  localparam int Q_HI = 3;
  localparam int Q_LO = 0;

  // Sign-extend a 4-bit two's complement component, scale it, keep 16 bits.
  function automatic logic [SAMP_COMP_BITS-1:0] expand_comp(
    input logic [COMP_BITS-1:0] comp,
    input int                   shift
  );
    logic [SAMP_COMP_BITS-1:0] ext;
    ext = {{(SAMP_COMP_BITS-COMP_BITS){comp[COMP_BITS-1]}}, comp};
    return ext << shift;
  endfunction

endpackage

// File: rtl/qpsk_sym_expand.sv
// Combinational expansion of one packed 8-bit QPSK symbol into a 32-bit I/Q sample.
module qpsk_sym_expand
  import qpsk_pkg::*;
#(
  parameter int SHIFT = 12
) (
  input  logic [SYM_BITS-1:0]  sym,
  output logic [SAMP_BITS-1:0] sample
);

  assign sample = {expand_comp(sym[I_HI:I_LO], SHIFT),
                   expand_comp(sym[Q_HI:Q_LO], SHIFT)};

endmodule

// File: rtl/qpsk_sample_unzip.sv
// Holds one packed input word and emits its four symbols as expanded samples,
// one per accepted output beat, refilling on the lane-3 beat without a bubble.
module qpsk_sample_unzip
  import qpsk_pkg::*;
#(
  parameter int SHIFT                = 12,
  parameter bit LANE_ORDER_MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [WORD_BITS-1:0] i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [SAMP_BITS-1:0] o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready
);

  logic [WORD_BITS-1:0] word_reg;
  logic                 last_reg;
  logic                 hold_valid;
  logic [1:0]           lane;
  logic [SYM_BITS-1:0]  lane_byte;
  logic                 lane_is_last;
  logic                 accept;
  logic                 beat;

  assign lane_is_last = (lane == 2'd3);
  assign i_tready     = ~hold_valid | (o_tready & lane_is_last);
  assign accept       = i_tvalid & i_tready;
  assign beat         = hold_valid & o_tready;

  assign o_tvalid = hold_valid;
  assign o_tlast  = hold_valid & last_reg & lane_is_last;

  // clear outranks a coincident accept, so a word offered during a flush is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_reg   <= '0;
      last_reg   <= 1'b0;
      hold_valid <= 1'b0;
      lane       <= 2'd0;
    end else if (clear) begin
      last_reg   <= 1'b0;
      hold_valid <= 1'b0;
      lane       <= 2'd0;
    end else if (accept) begin
      word_reg   <= i_tdata;
      last_reg   <= i_tlast;
      hold_valid <= 1'b1;
      lane       <= 2'd0;
    end else if (beat) begin
      if (lane_is_last) begin
        hold_valid <= 1'b0;
        lane       <= 2'd0;
      end else begin
        lane <= lane + 2'd1;
      end
    end
  end

  always_comb begin
    int lane_idx;
    lane_idx  = int'(lane);
    lane_byte = '0;
    if (LANE_ORDER_MSB_FIRST) begin
      lane_byte = word_reg[WORD_BITS-1-SYM_BITS*lane_idx -: SYM_BITS];
    end else begin
      lane_byte = word_reg[SYM_BITS*lane_idx +: SYM_BITS];
    end
  end

  qpsk_sym_expand #(
    .SHIFT (SHIFT)
  ) u_expand (
    .sym    (lane_byte),
    .sample (o_tdata)
  );

endmodule

// File: doc/qpsk_sample_unzip.md
Name: qpsk_sample_unzip

Overview:
- Downstream counterpart of the 8-bit symbol packer in the QPSK RFNoC chain.
- Accepts 32-bit AXI-Stream words, each holding four packed 8-bit symbols (4-bit I, 4-bit Q).
- Expands every symbol to a 32-bit sample: 16-bit I, 16-bit Q, sign-extended and scaled.
- Emits four output samples per input word at up to one sample per clock; feeds the modulator/DUC path.

Parameters:
- SHIFT, 12, left-shift applied to each sign-extended 4-bit component; legal range 0..12. At 12, code -8 maps to 0x8000 (full scale).
- LANE_ORDER_MSB_FIRST, 1. If 1, symbol 0 is taken from bits [31:24]. If 0, symbol 0 is taken from bits [7:0].

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush; discards the held word and any lanes not yet emitted
- i_tdata  in  32  four packed symbols. Each byte: I in [7:4], Q in [3:0], two's complement.
- i_tlast  in  1  last word of packet
- i_tvalid  in  1  input valid
- i_tready  out  1  input ready
- o_tdata  out  32  expanded sample: I in [31:16], Q in [15:0]
- o_tlast  out  1  asserted on lane 3 of a word that arrived with i_tlast
- o_tvalid  out  1  output valid
- o_tready  in  1  output ready

Behaviour:
- Registers:
  - word_reg[31:0]
  - last_reg
  - hold_valid
  - lane[1:0]
- Reset (async) values: word_reg=0, last_reg=0, hold_valid=0, lane=0.
- Outputs immediately after reset: o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=1.
- Handshakes:
  - i_tready = ~hold_valid | (o_tready & lane==3). Combinational, no dependency on i_tvalid.
  - Input accept (i_tvalid & i_tready): word_reg<=i_tdata, last_reg<=i_tlast, hold_valid<=1, lane<=0.
  - Output beat (o_tvalid & o_tready) with lane<3: lane<=lane+1.
  - Output beat with lane==3 and no simultaneous accept: hold_valid<=0, lane<=0.
- Combinational outputs:
  - o_tvalid = hold_valid.
  - o_tlast = hold_valid & last_reg & (lane==3).
  - o_tdata is a function of word_reg and lane. No extra pipeline stage.
- Latency and throughput:
  - Input accepted at cycle t; lane-0 sample valid at t+1.
  - Back-to-back words with o_tready held high give 4 samples per 4 cycles, with no bubble between words.
- Lane select:
  - LANE_ORDER_MSB_FIRST=1: byte = word_reg[31-8*lane -: 8].
  - Otherwise: byte = word_reg[8*lane +: 8].
- Expansion:
  - I16 = sign_extend(byte[7:4], 16) << SHIFT; Q16 likewise from byte[3:0].
  - Arithmetic is two's complement, truncated to 16 bits. No overflow is possible for SHIFT<=12.
- Backpressure: while o_tready=0, o_tdata, o_tlast and lane stay stable. AXI rule: valid is never withdrawn without a beat.
- Simultaneous lane-3 beat and input accept: new word loads, lane<=0, hold_valid stays 1.
- clear:
  - Next edge: hold_valid<=0, lane<=0, last_reg<=0.
  - clear has priority over both beat and accept in the same cycle; an accept coincident with clear is dropped.
  - i_tready still reads per formula in that cycle.
- reset mid-word: remaining lanes are lost; o_tvalid drops to 0 asynchronously.
- Packet framing: packet length out = 4 × packet length in. A one-word packet yields o_tlast on its 4th sample.
- Out of scope: partial words. Packets are always whole words.

Decomposition:
- Shared package (qpsk_pkg):
  - SYM_BITS=8, COMP_BITS=4, SAMP_COMP_BITS=16, SYMS_PER_WORD=4.
  - Byte-lane field positions (I_HI=7, I_LO=4, Q_HI=3, Q_LO=0).
  - These are also consumed by keep-one-in-n packer updates.
- One natural sub-module: qpsk_sym_expand. Pure combinational 8-bit symbol -> 32-bit sample, parameterized by SHIFT. Reused by any future loopback checker.
- Counter, holding register and handshake logic stay in the top module.

Test Plan:
1. Single word 0x1F807E09, i_tlast=1, o_tready=1, SHIFT=12:
   - outputs 0x1000F000, 0x80000000, 0x7000E000, 0x00009000.
   - o_tlast only on the 4th sample.
   - first o_tvalid one cycle after accept.
2. Streaming 16 random words, o_tready=1:
   - 64 samples, no idle cycles between words.
   - i_tready pulses only on lane-3 cycles after the first word.
   - output matches the scoreboard model.
3. Random o_tready (50%) and random i_tvalid over 200 words:
   - o_tdata/o_tlast stable while stalled.
   - no sample lost or duplicated.
   - o_tlast count equals input packet count.
4. SHIFT=0, LANE_ORDER_MSB_FIRST=0, word 0x000000F8:
   - first sample 0xFFFFFFF8 (I=-1, Q=-8).
   - the next three samples are 0x00000000.
5. Assert clear while lane==1 of word 0xAAAAAAAA:
   - o_tvalid=0 the next cycle.
   - the following word 0x11111111 emits 4 × 0x10001000 (SHIFT=12).
6. Assert reset asynchronously mid-lane-2, off clock edge:
   - o_tvalid, o_tlast, o_tdata go to 0 immediately; i_tready=1.
   - after release, the next word expands correctly from lane 0.
